// File: rtl/bintodec_7seg_scan.sv
// Binary to BCD converter (serial double-dabble) feeding a time-multiplexed common-anode 7-segment scanner.
// Conversion takes WIDTH+1 cycles after load; the display only ever shows committed bcd/ovf.
module bintodec_7seg_scan #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  load,
    output logic                  ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [SW-1:0] LAST_SCAN = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]   r_scratch;
    logic [BW-1:0]   w_adj;
    logic            r_sticky;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_bcd;
    logic            r_ovf;

    assign ready = (r_state == S_IDLE);
    assign bcd   = r_bcd;
    assign ovf   = r_ovf;

    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_sticky  <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_sticky  <= 1'b0;
                        r_cnt     <= CW'(WIDTH);
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    // Bit leaving the top nibble is worth 10^DIGITS; keep it only as a sticky flag.
                    r_scratch <= {w_adj[BW-2:0], r_shift[WIDTH-1]};
                    r_shift   <= r_shift << 1;
                    r_sticky  <= r_sticky | w_adj[BW-1];
                    r_cnt     <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1))
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_bcd   <= r_scratch;
                    r_ovf   <= r_sticky;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [SW-1:0] r_scan;
    logic [IW-1:0] r_idx;
    logic [6:0]    r_seg;
    logic [DIGITS-1:0] r_an;
    logic [BW-1:0] w_upper;
    logic          w_blank;
    logic [6:0]    w_seg;

    // w_upper holds the current digit and every more significant one, for blanking.
    assign w_upper = r_bcd >> {r_idx, 2'b00};
    assign w_blank = (BLANK_LZ != 0) && (r_idx != '0) && (w_upper == '0);
    assign w_seg   = r_ovf ? 7'b0111111 : (w_blank ? 7'b1111111 : seg7(w_upper[3:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_an   <= '1;
            r_seg  <= 7'b1111111;
        end else begin
            r_an  <= ~(DIGITS'(1) << r_idx);
            r_seg <= w_seg;
            if (r_scan == LAST_SCAN) begin
                r_scan <= '0;
                r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule
